// File: rtl/fp_norm_pkg.sv
// Shared constants and helpers for the mantissa normalizer family.
package fp_norm_pkg;

    localparam int unsigned DEF_WIDTH = 24;
    localparam int unsigned DEF_GROUP = 8;

    // Ceiling log2; clog2(0) and clog2(1) both return 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned x;
        int unsigned r;
        x = (v > 0) ? v - 1 : 0;
        r = 0;
        while (x != 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lead_one_group.sv
// GROUP-bit priority encoder: nonzero flag plus local index of the highest set bit.
module lead_one_group #(
    parameter int unsigned GROUP = 8,
    parameter int unsigned LIW   = 3
) (
    input  logic [GROUP-1:0] data_i,
    output logic             nz_o,
    output logic [LIW-1:0]   idx_o
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        nz_o  = |data_i;
        idx_o = '0;
        for (int unsigned i = 0; i < GROUP; i++) begin
            if (data_i[i]) begin
                idx_o = LIW'(i);
            end
        end
    end

endmodule

// File: rtl/lead_one_normalizer.sv
// Two-stage elastic leading-one detector / normalizer.
// S1 registers per-group priority results and the raw mantissa;
// S2 merges the groups and produces index, leading-zero count and shifted mantissa.
module lead_one_normalizer
    import fp_norm_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned GROUP = DEF_GROUP,
    localparam int unsigned IW    = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1,
    localparam int unsigned LW    = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_idx,
    output logic [LW-1:0]    out_lzc,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm
);

    localparam int unsigned NG  = WIDTH / GROUP;
    localparam int unsigned LIW = (clog2(GROUP) > 0) ? clog2(GROUP) : 1;

    if (WIDTH % GROUP != 0) begin : g_bad_group
        $error("lead_one_normalizer: WIDTH must be a multiple of GROUP");
    end

    // First-level group encoders on the incoming mantissa
    logic [NG-1:0]          grp_nz;
    logic [NG-1:0][LIW-1:0] grp_idx;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        lead_one_group #(
            .GROUP (GROUP),
            .LIW   (LIW)
        ) u_grp (
            .data_i (in_data[g*GROUP +: GROUP]),
            .nz_o   (grp_nz[g]),
            .idx_o  (grp_idx[g])
        );
    end

    // Pipeline state
    logic                   s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]       s1_data_q;
    logic [NG-1:0]          s1_nz_q;
    logic [NG-1:0][LIW-1:0] s1_lidx_q;

    logic                   s2_valid_q, s2_valid_d;
    logic [IW-1:0]          s2_idx_q, s2_idx_d;
    logic [LW-1:0]          s2_lzc_q, s2_lzc_d;
    logic                   s2_zero_q, s2_zero_d;
    logic [WIDTH-1:0]       s2_norm_q, s2_norm_d;

    logic s1_en;
    logic s2_en;

    // Stage enables: load when empty or when the current contents leave
    always_comb begin
        s2_en      = !s2_valid_q || out_ready;
        s1_en      = !s1_valid_q || s2_en;
        s1_valid_d = s1_en ? in_valid   : s1_valid_q;
        s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
    end

    assign in_ready = s1_en;

    // Valid bits, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // S1 payload: raw data and per-group encoder results
    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            s1_data_q <= in_data;
            s1_nz_q   <= grp_nz;
            s1_lidx_q <= grp_idx;
        end
    end

    // S2 merge: highest nonzero group wins, then count and shift
    always_comb begin
        s2_idx_d = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            if (s1_nz_q[g]) begin
                s2_idx_d = IW'(g * GROUP + 32'(s1_lidx_q[g]));
            end
        end
        s2_zero_d = ~|s1_nz_q;
        s2_lzc_d  = s2_zero_d ? LW'(WIDTH) : LW'(WIDTH - 1 - 32'(s2_idx_d));
        s2_norm_d = s1_data_q << s2_lzc_d;
    end

    // S2 payload drives the outputs directly, so it is reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_idx_q  <= '0;
            s2_lzc_q  <= '0;
            s2_zero_q <= 1'b0;
            s2_norm_q <= '0;
        end else if (s2_en && s1_valid_q) begin
            s2_idx_q  <= s2_idx_d;
            s2_lzc_q  <= s2_lzc_d;
            s2_zero_q <= s2_zero_d;
            s2_norm_q <= s2_norm_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_idx   = s2_idx_q;
    assign out_lzc   = s2_lzc_q;
    assign out_zero  = s2_zero_q;
    assign out_norm  = s2_norm_q;

endmodule

// File: doc/lead_one_normalizer.md
LEAD_ONE_NORMALIZER -- requirements
Module: lead_one_normalizer

Interface
REQ-001 Parameter WIDTH, default 24: mantissa width in bits.
REQ-002 Parameter GROUP, default 8: bits per first-level priority group; WIDTH SHALL be an integer multiple of GROUP.
REQ-003 Derived widths: IW = clog2(WIDTH) for the index, LW = clog2(WIDTH+1) for the count.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  WIDTH  unsigned mantissa to normalize.
REQ-009 out_valid  output  1  result outputs are valid.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 out_idx  output  IW  bit index of the most-significant set bit of in_data.
REQ-012 out_lzc  output  LW  leading-zero count: WIDTH-1-out_idx, or WIDTH when in_data is zero.
REQ-013 out_zero  output  1  in_data was all zeros.
REQ-014 out_norm  output  WIDTH  in_data shifted left by out_lzc, MSB set unless out_zero.

Function
REQ-015 Transfer: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-016 Two-stage elastic pipeline (S1, S2), each stage holding a valid bit and a payload register.
REQ-017 S1 SHALL register, per group g, a group-nonzero flag and the GROUP-local index of that group's highest set bit, plus the raw in_data.
REQ-018 S2 SHALL select the highest-numbered nonzero group, form out_idx = g*GROUP + local index, and compute out_lzc, out_zero and out_norm.
REQ-019 Latency: an accepted input SHALL appear on the outputs exactly 2 cycles later when there is no back-pressure.
REQ-020 Throughput: one result per cycle while out_ready is held high.
REQ-021 Stage enable: a stage SHALL load when it is empty or its contents leave this cycle; in_ready = !S1.valid || S1 advances (combinational, no dependency on in_valid).
REQ-022 Back-pressure: with out_ready low, results SHALL hold stable and S2 then S1 SHALL fill, after which in_ready goes low; no data lost or duplicated.
REQ-023 Simultaneous output consume and input accept on a full pipeline SHALL advance both stages in the same cycle.
REQ-024 Zero input: out_zero=1, out_idx=0, out_lzc=WIDTH, out_norm=0.
REQ-025 Result outputs SHALL be held constant while out_valid && !out_ready.
REQ-026 Ordering SHALL be strictly FIFO.

Reset
REQ-027 On rst_n low, S1.valid, S2.valid and out_valid SHALL clear immediately; out_idx, out_lzc, out_norm and out_zero SHALL be 0.
REQ-028 Reset mid-operation SHALL discard all in-flight data; after release, in_ready=1 on the first cycle.
REQ-029 Payload registers need not be reset other than those driving outputs.

Structure
REQ-030 Shared package fp_norm_pkg SHALL hold the clog2 helper and the default WIDTH and GROUP constants.
REQ-031 One sub-module, lead_one_group: a GROUP-bit priority encoder giving a nonzero flag and the local index of the highest set bit, instantiated WIDTH/GROUP times.
REQ-032 Elaboration SHALL fail when WIDTH % GROUP != 0.

Verification (WIDTH=24, GROUP=8)
REQ-033 in_data=24'h800000 -> 2 cycles later: idx=23, lzc=0, zero=0, norm=24'h800000.
REQ-034 in_data=24'h000001 -> idx=0, lzc=23, norm=24'h800000; in_data=24'h00A5F0 -> idx=15, lzc=8, norm=24'hA5F000.
REQ-035 in_data=0 -> zero=1, idx=0, lzc=24, norm=0.
REQ-036 Stream 10 random values, out_ready low for 5 cycles mid-stream -> in_ready drops after 2 accepts, outputs held stable, all 10 results emitted in order.
REQ-037 Assert rst_n low with both stages valid -> out_valid=0 immediately; after release, the first new input yields exactly one result.
REQ-038 Continuous in_valid with out_ready=1 -> one result per cycle, no bubbles, matching the reference model.
